// File: rtl/selector41_rr.sv
// Round-robin 4-to-1 time-division selector: grants one requesting channel per
// fixed-length slot and drives the serial (oC, oS1, oS0) link to the far end.
module selector41_rr #(
    parameter int HOLD = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iZ0,
    input  logic iZ1,
    input  logic iZ2,
    input  logic iZ3,
    output logic oC,
    output logic oS1,
    output logic oS0,
    output logic oBusy,
    output logic oSlotEnd
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST = 8'(HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  zr_q;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        c_q, c_d;
    logic        slot_end_q, slot_end_d;
    logic [3:0]  req_s;
    logic [1:0]  start_s;
    logic        grant_s;

    // First requesting channel in rotation order starting at 'start'.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    assign req_s = ~zr_q;

    // Slot sequencing, arbitration and next output values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        c_d        = c_q;
        slot_end_d = 1'b0;
        grant_s    = 1'b0;
        start_s    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                c_d = 1'b1;
                if (iEn && (req_s != 4'b0000)) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                c_d = zr_q[sel_q];
                if (cnt_q == LAST) begin
                    ptr_d   = sel_q + 2'd1;
                    start_s = sel_q + 2'd1;
                    if (iEn && (req_s != 4'b0000)) begin
                        grant_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        c_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                c_d     = 1'b1;
            end
        endcase
        if (grant_s) begin
            sel_d   = rr_pick(req_s, start_s);
            state_d = ST_HOLD;
            cnt_d   = 8'd0;
            c_d     = zr_q[sel_d];
        end else begin
            sel_d = sel_d;
        end
        slot_end_d = (state_d == ST_HOLD) && (cnt_d == LAST);
    end

    // Input sampling stage and all registered state/outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            zr_q       <= 4'b1111;
            ptr_q      <= 2'd0;
            cnt_q      <= 8'd0;
            sel_q      <= 2'd0;
            c_q        <= 1'b1;
            slot_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            zr_q       <= {iZ3, iZ2, iZ1, iZ0};
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            c_q        <= c_d;
            slot_end_q <= slot_end_d;
        end
    end

    assign oC       = c_q;
    assign oS1      = sel_q[1];
    assign oS0      = sel_q[0];
    assign oBusy    = (state_q == ST_HOLD);
    assign oSlotEnd = slot_end_q;

endmodule
